// File: rtl/fifo_port_ctrl.sv
// fifo_port_ctrl: round-robin write arbiter, registered read port
// and shadow occupancy checker for a small synchronous FIFO.
module fifo_port_ctrl #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          SYSCLK,
  input  logic          RST_B,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic [DW-1:0] DIN0,
  input  logic [DW-1:0] DIN1,
  output logic          ACK0,
  output logic          ACK1,
  output logic          FIFO_WR_EN,
  output logic [DW-1:0] FIFO_IN,
  output logic          FIFO_RD_EN,
  input  logic          FIFO_FULL,
  input  logic          FIFO_EMPTY,
  input  logic [DW-1:0] FIFO_OUT,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_VLD,
  input  logic          DOUT_RDY,
  output logic [LW-1:0] LEVEL,
  output logic          ERR
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } rd_state_t;

  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  rd_state_t state, state_nxt;
  logic      pri;
  logic      elig0, elig1;
  logic      gnt0, gnt1;
  logic      cap;
  logic      lvl_inc, lvl_dec;
  logic      ovf, unf, flag_bad;

  // pri names the requester that wins when both are eligible
  assign elig0 = REQ0 & ~FIFO_FULL;
  assign elig1 = REQ1 & ~FIFO_FULL;
  assign gnt0  = elig0 & (~elig1 | ~pri);
  assign gnt1  = elig1 & (~elig0 | pri);

  assign ACK0       = gnt0;
  assign ACK1       = gnt1;
  assign FIFO_WR_EN = gnt0 | gnt1;
  assign FIFO_IN    = gnt1 ? DIN1 : DIN0;

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      pri <= 1'b0;
    end else if (gnt0 | gnt1) begin
      pri <= ~gnt1;
    end
  end

  always_comb begin
    state_nxt  = state;
    FIFO_RD_EN = 1'b0;
    cap        = 1'b0;
    case (state)
      IDLE: begin
        if (!FIFO_EMPTY) begin
          FIFO_RD_EN = 1'b1;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        cap       = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (DOUT_RDY) begin
          if (!FIFO_EMPTY) begin
            FIFO_RD_EN = 1'b1;
            state_nxt  = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state    <= IDLE;
      DOUT     <= '0;
      DOUT_VLD <= 1'b0;
    end else begin
      state    <= state_nxt;
      DOUT_VLD <= (state_nxt == HOLD);
      if (cap) begin
        DOUT <= FIFO_OUT;
      end
    end
  end

  // a same-cycle read and write cancel out
  assign lvl_inc  = FIFO_WR_EN & ~FIFO_RD_EN;
  assign lvl_dec  = FIFO_RD_EN & ~FIFO_WR_EN;
  assign ovf      = lvl_inc & (LEVEL == LVL_MAX);
  assign unf      = lvl_dec & (LEVEL == '0);
  assign flag_bad = ((LEVEL == LVL_MAX) != FIFO_FULL)
                  | ((LEVEL == '0) != FIFO_EMPTY);

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      LEVEL <= '0;
      ERR   <= 1'b0;
    end else begin
      if (lvl_inc && !ovf) begin
        LEVEL <= LEVEL + 1'b1;
      end else if (lvl_dec && !unf) begin
        LEVEL <= LEVEL - 1'b1;
      end
      ERR <= ERR | ovf | unf | flag_bad;
    end
  end

endmodule

// File: tb/tb_fifo_port_ctrl.sv
// tb_fifo_port_ctrl: directed bench with a 4-deep FIFO model
// between the controller's write and read ports.
module tb_fifo_port_ctrl;

  logic       clk;
  logic       rst_b;
  logic       req0, req1;
  logic [7:0] din0, din1;
  logic       ack0, ack1;
  logic       wr_en, rd_en;
  logic [7:0] fifo_in, fifo_out;
  logic       fifo_full, fifo_empty;
  logic [7:0] dout;
  logic       dout_vld, dout_rdy;
  logic [2:0] level;
  logic       err;
  logic       force_ne;

  int n_chk  = 0;
  int n_fail = 0;
  int bad_rd = 0;
  int cyc    = 0;
  logic [7:0] rxq[$];
  int         rxt[$];

  fifo_port_ctrl #(.DW(8), .DEPTH(4)) dut (
    .SYSCLK    (clk),
    .RST_B     (rst_b),
    .REQ0      (req0),
    .REQ1      (req1),
    .DIN0      (din0),
    .DIN1      (din1),
    .ACK0      (ack0),
    .ACK1      (ack1),
    .FIFO_WR_EN(wr_en),
    .FIFO_IN   (fifo_in),
    .FIFO_RD_EN(rd_en),
    .FIFO_FULL (fifo_full),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_OUT  (fifo_out),
    .DOUT      (dout),
    .DOUT_VLD  (dout_vld),
    .DOUT_RDY  (dout_rdy),
    .LEVEL     (level),
    .ERR       (err)
  );

  // FIFO model: registered read data, flags from count
  logic [7:0] mem[4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic       wr_ok, rd_ok;

  assign wr_ok      = wr_en && (cnt != 3'd4);
  assign rd_ok      = rd_en && (cnt != 3'd0);
  assign fifo_full  = (cnt == 3'd4);
  assign fifo_empty = (cnt == 3'd0) && !force_ne;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wp       <= 0;
      rp       <= 0;
      cnt      <= 0;
      fifo_out <= 0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= fifo_in;
        wp      <= wp + 1;
      end
      if (rd_ok) begin
        fifo_out <= mem[rp];
        rp       <= rp + 1;
      end
      cnt <= cnt + {2'b0, wr_ok} - {2'b0, rd_ok};
    end
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_b && dout_vld && dout_rdy) begin
      rxq.push_back(dout);
      rxt.push_back(cyc);
    end
    if (rst_b && rd_en && fifo_empty) bad_rd <= bad_rd + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1; req0 = 0; req1 = 0;
    din0 = 0; din1 = 0; dout_rdy = 0; force_ne = 0;
    #1 rst_b = 0;
    #11 rst_b = 1; req0 = 1; din0 = 8'h55;
    #17;
    check("pre_rst_level", level, 1);
    #1 rst_b = 0; req0 = 0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_vld", dout_vld, 0);
    check("rst_level", level, 0);
    check("rst_err", err, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    #9 rst_b = 1;

    // single producer, consumer stalled
    tick();
    req0 = 1; din0 = 8'd11;
    #1;
    check("w11_ack0", ack0, 1);
    check("w11_ack1", ack1, 0);
    check("w11_wr_en", wr_en, 1);
    check("w11_in", fifo_in, 11);
    tick();
    check("w11_level", level, 1);
    din0 = 8'd24;
    #1;
    check("w24_ack0", ack0, 1);
    check("first_rd", rd_en, 1);
    tick();
    check("w24_level", level, 1);
    din0 = 8'd31;
    #1;
    check("w31_ack0", ack0, 1);
    check("wait_no_rd", rd_en, 0);
    tick();
    check("cap11_dout", dout, 11);
    check("cap11_vld", dout_vld, 1);
    check("w31_level", level, 2);
    din0 = 8'd46;
    #1;
    check("w46_ack0", ack0, 1);
    tick();
    check("w46_level", level, 3);
    check("w46_full", fifo_full, 0);
    din0 = 8'd57;
    #1;
    check("w57_ack0", ack0, 1);
    tick();
    check("w57_level", level, 4);
    check("w57_full", fifo_full, 1);
    din0 = 8'd99;
    #1;
    check("full_ack0", ack0, 0);
    check("full_wr_en", wr_en, 0);
    check("full_err", err, 0);

    // backpressure
    req0 = 0; dout_rdy = 1;
    #1;
    check("hold_rd", rd_en, 1);
    tick();
    check("wait_vld", dout_vld, 0);
    dout_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_dout", dout, 24);
      check("bp_vld", dout_vld, 1);
    end
    dout_rdy = 1;
    tick();
    check("bp_wait_vld", dout_vld, 0);
    rxq.delete();
    rxt.delete();
    tick();
    check("bp_next_dout", dout, 31);
    check("bp_next_vld", dout_vld, 1);

    // drain to empty
    repeat (5) tick();
    check("drain_cnt", rxq.size(), 3);
    if (rxq.size() == 3) begin
      check("drain_w0", rxq[0], 31);
      check("drain_w1", rxq[1], 46);
      check("drain_w2", rxq[2], 57);
      check("drain_gap0", rxt[1] - rxt[0], 2);
      check("drain_gap1", rxt[2] - rxt[1], 2);
    end
    check("drain_vld", dout_vld, 0);
    check("drain_rd_en", rd_en, 0);
    check("drain_level", level, 0);
    check("drain_err", err, 0);
    check("rd_while_empty", bad_rd, 0);

    // contention
    rst_b = 0;
    #2 rst_b = 1;
    tick();
    req0 = 1; req1 = 1; din0 = 8'hA0; din1 = 8'hB1;
    rxq.delete();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("arb_ack0", ack0, (i % 2) == 0);
      check("arb_ack1", ack1, (i % 2) == 1);
      check("arb_in", fifo_in, (i % 2) == 0 ? 8'hA0 : 8'hB1);
      tick();
    end
    req0 = 0; req1 = 0;
    repeat (7) tick();
    check("arb_cnt", rxq.size(), 4);
    if (rxq.size() == 4) begin
      check("arb_r0", rxq[0], 8'hA0);
      check("arb_r1", rxq[1], 8'hB1);
      check("arb_r2", rxq[2], 8'hA0);
      check("arb_r3", rxq[3], 8'hB1);
    end
    check("arb_level", level, 0);

    // flag cross-check
    check("xchk_err0", err, 0);
    force_ne = 1;
    tick();
    check("xchk_err1", err, 1);
    force_ne = 0;
    repeat (2) tick();
    check("xchk_sticky", err, 1);
    rst_b = 0;
    #1;
    check("xchk_rst", err, 0);
    rst_b = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
